// File: rtl/alu_pkg.sv
// Shared types for the integer execute unit: FSM states, funct3 codes and the
// captured-operation record. Used with or without ALU_ITER_SHIFT_EN.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic       is_imm;
    logic [2:0] funct3;
    logic       funct7_b5;
  } alu_op_t;

  function automatic logic is_shift_op(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SR);
  endfunction

  // Immediate forms never subtract, whatever instr[30] holds.
  function automatic logic is_sub_op(input alu_op_t op);
    return !op.is_imm && op.funct7_b5 && (op.funct3 == F3_ADD);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter with its remaining-count register.
// Only instantiated by alu_exec when ALU_ITER_SHIFT_EN is defined.
module alu_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dir,
  input  logic               arith,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [XLEN-1:0]    value,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result
);

  logic [XLEN-1:0]    val_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               busy_q;
  logic               dir_q;
  logic               arith_q;

  // dir = 1 shifts right; arith replicates the sign bit on each right step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (start) begin
      val_q   <= value;
      cnt_q   <= shamt;
      busy_q  <= 1'b1;
      dir_q   <= dir;
      arith_q <= arith;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - SHAMT_W'(1);
        if (dir_q)
          val_q <= {arith_q & val_q[XLEN-1], val_q[XLEN-1:1]};
        else
          val_q <= {val_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign busy   = busy_q;
  assign done   = busy_q && (cnt_q == '0);
  assign result = val_q;

endmodule

// File: rtl/alu_exec.sv
// Handshaked OP / OP-IMM integer execute unit with a registered result.
// Define ALU_ITER_SHIFT_EN to replace the barrel shifter with alu_shifter.
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_imm,
  input  logic [2:0]      funct3,
  input  logic            funct7_b5,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("alu_exec: XLEN must be 32 or 64");
    end
  endgenerate

  alu_state_e         state, state_nxt;
  alu_op_t            op;
  logic               accept;
  logic               go_shift;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_val;
  logic [XLEN-1:0]    result_q;

  assign op        = '{is_imm: is_imm, funct3: funct3, funct7_b5: funct7_b5};
  assign shamt     = op2[SHAMT_W-1:0];
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign result    = result_q;

`ifdef ALU_ITER_SHIFT_EN
  logic            sh_busy;
  logic            sh_done;
  logic [XLEN-1:0] sh_result;

  assign go_shift = is_shift_op(op.funct3);

  alu_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && go_shift),
    .dir    (op.funct3 == F3_SR),
    .arith  (op.funct7_b5),
    .shamt  (shamt),
    .value  (rs1),
    .busy   (sh_busy),
    .done   (sh_done),
    .result (sh_result)
  );

  assign in_ready = !rst && !sh_busy &&
                    ((state == IDLE) || ((state == DONE) && out_ready));
`else
  logic signed [XLEN-1:0] sra_val;

  // Kept in its own signed net so the arithmetic shift is not flattened
  // to a logical one by an unsigned surrounding expression.
  assign sra_val  = $signed(rs1) >>> shamt;
  assign go_shift = 1'b0;
  assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
`endif

  always_comb begin
    alu_val = '0;
    case (op.funct3)
      F3_ADD:  alu_val = is_sub_op(op) ? (rs1 - op2) : (rs1 + op2);
`ifndef ALU_ITER_SHIFT_EN
      F3_SLL:  alu_val = rs1 << shamt;
      F3_SR:   alu_val = op.funct7_b5 ? sra_val : (rs1 >> shamt);
`endif
      F3_SLT:  alu_val = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(op2))};
      F3_SLTU: alu_val = {{(XLEN-1){1'b0}}, (rs1 < op2)};
      F3_XOR:  alu_val = rs1 ^ op2;
      F3_OR:   alu_val = rs1 | op2;
      F3_AND:  alu_val = rs1 & op2;
      default: alu_val = '0;
    endcase
  end

  // DONE doubles as the output register stage; a new accept there keeps
  // the pipe full at one operation per cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept)
          state_nxt = go_shift ? SHIFT : DONE;
      end
`ifdef ALU_ITER_SHIFT_EN
      SHIFT: begin
        if (sh_done)
          state_nxt = DONE;
      end
`endif
      DONE: begin
        if (out_ready)
          state_nxt = accept ? (go_shift ? SHIFT : DONE) : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept && !go_shift)
        result_q <= alu_val;
`ifdef ALU_ITER_SHIFT_EN
      else if ((state == SHIFT) && sh_done)
        result_q <= sh_result;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: scoreboarded 32-bit unit plus a 64-bit
// instance for wide shifts. Latency expectations follow ALU_ITER_SHIFT_EN.
module tb_alu_exec;

`ifdef ALU_ITER_SHIFT_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, is_imm, funct7_b5, out_valid, out_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1, op2, result;

  logic        in_valid64, in_ready64, is_imm64, funct7_64, out_valid64, out_ready64;
  logic [2:0]  funct3_64;
  logic [63:0] rs1_64, op2_64, result64;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] expq[$];
  logic [31:0] expVal;

  alu_exec #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_imm    (is_imm),
    .funct3    (funct3),
    .funct7_b5 (funct7_b5),
    .rs1       (rs1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  alu_exec #(.XLEN(64)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid64),
    .in_ready  (in_ready64),
    .is_imm    (is_imm64),
    .funct3    (funct3_64),
    .funct7_b5 (funct7_64),
    .rs1       (rs1_64),
    .op2       (op2_64),
    .out_valid (out_valid64),
    .out_ready (out_ready64),
    .result    (result64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    assert (got === exp) passCount++;
    else $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Independent reference: shifts by repeated single steps, SLT by sign analysis.
  function automatic logic [31:0] refAlu(input logic imm, input logic [2:0] f3, input logic f7,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int          s;
    s = int'(b[4:0]);
    r = a;
    case (f3)
      3'd0: r = (!imm && f7) ? a + (~b + 32'd1) : a + b;
      3'd1: for (int k = 0; k < s; k++) r = {r[30:0], 1'b0};
      3'd2: r = ((a[31] != b[31]) ? a[31] : (a < b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: for (int k = 0; k < s; k++) r = {f7 & r[31], r[31:1]};
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic applyStimulus(input logic imm, input logic [2:0] f3, input logic f7,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    int guard;
    guard     = 0;
    is_imm    = imm;
    funct3    = f3;
    funct7_b5 = f7;
    rs1       = a;
    op2       = b;
    in_valid  = 1'b1;
    #1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checkOutput("accept_wait", 64'(guard < 200), 64'd1);
    @(posedge clk);
    expq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic measureLatency(input string tag, input int expLat);
    int   cyc;
    logic irSeen;
    cyc    = 0;
    irSeen = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) irSeen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    checkOutput(tag, 64'(cyc), 64'(expLat));
    checkOutput({tag, "_inready"}, 64'(irSeen), 64'd0);
  endtask

  task automatic run64(input string tag, input logic f7, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] e, input int expLat);
    int cyc;
    int guard;
    guard      = 0;
    is_imm64   = 1'b0;
    funct3_64  = 3'b101;
    funct7_64  = f7;
    rs1_64     = a;
    op2_64     = b;
    in_valid64 = 1'b1;
    #1;
    while (!in_ready64 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid64 = 1'b0;
    cyc = 0;
    while (!out_valid64 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_latency"}, 64'(cyc), 64'(expLat));
    checkOutput({tag, "_result"}, result64, e);
    @(negedge clk);
  endtask

  // Scoreboard side: a transfer happens when both valid and ready are high.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        checkCount++;
        assert (expq.size() > 0) passCount++;
        else $error("[TB] FAIL sb_unexpected: result %0h with nothing expected", result);
        if (expq.size() > 0) begin
          expVal = expq.pop_front();
          checkOutput("sb_result", 64'(result), 64'(expVal));
        end
      end
    end
  end

  initial begin
    logic seen;
    rst = 1'b1;
    in_valid = 1'b0; is_imm = 1'b0; funct3 = '0; funct7_b5 = 1'b0;
    rs1 = '0; op2 = '0; out_ready = 1'b1;
    in_valid64 = 1'b0; is_imm64 = 1'b0; funct3_64 = '0; funct7_64 = 1'b0;
    rs1_64 = '0; op2_64 = '0; out_ready64 = 1'b1;

    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] directed arithmetic, compare, logic and shift ops");
    applyStimulus(1'b0, 3'd0, 1'b0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000);
    applyStimulus(1'b0, 3'd0, 1'b1, 32'd5,         32'd7,         32'hFFFF_FFFE);
    applyStimulus(1'b1, 3'd0, 1'b1, 32'd5,         32'd7,         32'd12);
    applyStimulus(1'b0, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'd1);
    applyStimulus(1'b0, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'd0);
    applyStimulus(1'b1, 3'd3, 1'b0, 32'd5,         32'hFFFF_F800, 32'd1);
    applyStimulus(1'b0, 3'd5, 1'b1, 32'h8000_0000, 32'd4,         32'hF800_0000);
    applyStimulus(1'b1, 3'd5, 1'b1, 32'h8000_0000, 32'h0000_0404, 32'hF800_0000);
    applyStimulus(1'b0, 3'd5, 1'b0, 32'h8000_0000, 32'hFFFF_FFE4, 32'h0800_0000);
    applyStimulus(1'b0, 3'd4, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    applyStimulus(1'b0, 3'd6, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    applyStimulus(1'b0, 3'd7, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    repeat (40) @(negedge clk);

    $display("[TB] latency of shifts and plain ops");
    applyStimulus(1'b0, 3'd1, 1'b0, 32'h1, 32'd31, 32'h8000_0000);
    measureLatency("lat_sll31", ITER ? 32 : 0);
    applyStimulus(1'b1, 3'd1, 1'b0, 32'h0000_1234, 32'd0, 32'h0000_1234);
    measureLatency("lat_sll0", ITER ? 1 : 0);
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd40, 32'd2, 32'd42);
    measureLatency("lat_add", 0);
    @(negedge clk);

    $display("[TB] back-pressure with three queued adds");
    out_ready = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd1, 32'd2, 32'd3);
    is_imm = 1'b0; funct3 = 3'd0; funct7_b5 = 1'b0; rs1 = 32'd10; op2 = 32'd20;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_result", 64'(result), 64'd3);
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd10, 32'd20, 32'd30);
    checkOutput("b2b_valid2", 64'(out_valid), 64'd1);
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd100, 32'd200, 32'd300);
    checkOutput("b2b_valid3", 64'(out_valid), 64'd1);
    repeat (3) @(negedge clk);

    $display("[TB] random operations against the reference model");
    for (int i = 0; i < 16; i++) begin
      logic        rImm, rF7;
      logic [2:0]  rF3;
      logic [31:0] ra, rb;
      rImm = 1'($urandom_range(0, 1));
      rF7  = 1'($urandom_range(0, 1));
      rF3  = 3'($urandom_range(0, 7));
      ra   = $urandom;
      rb   = $urandom;
      applyStimulus(rImm, rF3, rF7, ra, rb, refAlu(rImm, rF3, rF7, ra, rb));
    end
    repeat (80) @(negedge clk);

    $display("[TB] reset during an in-flight SRL by 20");
    out_ready = 1'b0;
    applyStimulus(1'b0, 3'd5, 1'b0, 32'hFFFF_0000, 32'd20, 32'h0000_0FFF);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_result", 64'(result), 64'd0);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd0);
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput("abort_no_result", 64'(seen), 64'd0);
    checkOutput("abort_result_held", 64'(result), 64'd0);

    $display("[TB] XLEN=64 wide shifts");
    run64("x64_sra63", 1'b1, 64'h8000_0000_0000_0000, 64'h7F, 64'hFFFF_FFFF_FFFF_FFFF, ITER ? 64 : 0);
    run64("x64_srl4",  1'b0, 64'h8000_0000_0000_0000, 64'h44, 64'h0800_0000_0000_0000, ITER ? 5 : 0);

    repeat (5) @(negedge clk);
    checkOutput("sb_drained", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Parametrised, handshaked integer execute unit for the RISC-V core. It replaces the purely combinational I-type datapath and covers both OP-IMM and OP (R-type) base-integer operations at XLEN 32 or 64. Operands and decoded fields arrive from decode over a valid/ready channel. A registered result leaves toward writeback over a second valid/ready channel. An optional iterative shifter trades latency for area.

## Interface
Parameters:
- `XLEN`, default 32: datapath width. Only 32 or 64 are legal; any other value is an elaboration error.
- `SHAMT_W`, default `$clog2(XLEN)`: shift-amount width. Derived; do not override.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: operation presented.
- `in_ready`, out, 1: unit can accept an operation.
- `is_imm`, in, 1: 1 = OP-IMM, 0 = OP.
- `funct3`, in, 3: `instr[14:12]`.
- `funct7_b5`, in, 1: `instr[30]`. Selects SUB and SRA/SRAI.
- `rs1`, in, XLEN: first operand.
- `op2`, in, XLEN: rs2 value, or the immediate already sign-extended to XLEN.
- `out_valid`, out, 1: result held.
- `out_ready`, in, 1: writeback accepts the result.
- `result`, out, XLEN: computed value.

## Operation
- An operation is accepted when `in_valid && in_ready`. All inputs are captured on that edge and may change afterwards.
- funct3 decode:
  - 000: ADD. Becomes SUB when `!is_imm && funct7_b5`. In OP-IMM, `funct7_b5` is ignored, so this is always ADDI.
  - 001: SLL.
  - 010: SLT, signed compare.
  - 011: SLTU, unsigned compare over the full XLEN of both operands.
  - 100: XOR.
  - 101: SRL when `funct7_b5` = 0; SRA (arithmetic) when 1. Applies to both OP and OP-IMM.
  - 110: OR.
  - 111: AND.
- Shift amount is `op2[SHAMT_W-1:0]`; upper bits of `op2` are ignored.
- SLT and SLTU return 1 or 0, zero-extended to XLEN.
- All arithmetic wraps modulo 2^XLEN. No overflow flag.
- FSM states, encoded in the package:
  - IDLE:
    - accept of a shift with `ALU_ITER_SHIFT_EN` defined → SHIFT.
    - accept of any other operation → DONE.
  - SHIFT: one bit position per cycle. Goes to DONE when the remaining count reaches 0.
  - DONE: `out_valid` = 1 and `result` is stable.
    - `out_ready` with `in_valid` → accept the next operation and branch as from IDLE.
    - `out_ready` without `in_valid` → IDLE.
- `in_ready` = (state == IDLE) || (state == DONE && `out_ready`). It is forced to 0 while `rst` is high.

## Timing
- Reset values: `out_valid` = 0, `result` = 0, state = IDLE, shift counter = 0.
- Reset asserted mid-SHIFT or in DONE aborts the operation. The pending result is discarded and no `out_valid` pulse follows.
- Non-shift operations, and all shifts without the macro: latency 1. `out_valid` rises on the edge after accept.
- Iterative shift: latency = shamt + 1 cycles.
  - shamt = 0 still spends one SHIFT cycle; result = `rs1`.
  - shamt = XLEN-1 gives the maximum latency, XLEN cycles.
- Back-to-back throughput is 1 operation per cycle while `out_ready` stays high and no iterative shift is in flight.
- `result` and `out_valid` do not change while `out_valid && !out_ready`, however many stall cycles occur.
- `in_ready` is 0 throughout SHIFT.

## Configuration
- Macro: `ALU_ITER_SHIFT_EN`.
- Defined: SLL, SRL and SRA use an iterative shifter, one bit per cycle, and go through SHIFT. SRA replicates the sign bit on every step.
- Undefined: a single-cycle barrel shifter is used. The SHIFT state and the shift counter are not built, and every operation takes the latency-1 path.

## Structure
- Package `alu_pkg` holds:
  - `alu_state_e` (IDLE, SHIFT, DONE).
  - funct3 localparams (`F3_ADD` … `F3_AND`).
  - `alu_op_t`: a struct of the captured fields.
- Sub-module `alu_shifter` contains the iterative shift datapath and its counter. Ports: start, dir, arith, shamt, value; outputs busy, done, result. It is instantiated only under `ALU_ITER_SHIFT_EN`.

## Test plan
- Reset with ops pending: assert `rst` mid-SHIFT on an SRL with shamt 20 → `out_valid` drops to 0 asynchronously, `result` = 0, and no result appears after release.
- Arithmetic at XLEN=32:
  - ADD with rs1 = 0x7FFFFFFF, op2 = 1 → 0x80000000.
  - SUB (`!is_imm`, `funct7_b5` = 1) with 5 − 7 → 0xFFFFFFFE.
  - ADDI with `funct7_b5` = 1 → still an add.
- Compares, rs1 = 0xFFFFFFFF and op2 = 1:
  - SLT → 1.
  - SLTU → 0.
  - SLTU with op2 = 0xFFFFF800 against rs1 = 5 → 1.
- Shifts, rs1 = 0x80000000, shamt 4:
  - SRA → 0xF8000000.
  - SRL → 0x08000000.
- Iterative shift (macro defined): SLL with shamt 31 → `out_valid` 32 cycles after accept, and `in_ready` = 0 throughout. shamt 0 → 1 cycle, result = `rs1`.
- Back-pressure: 3 back-to-back ADDs with `out_ready` held 0 for 5 cycles → the first result stays stable, `in_ready` = 0, and after release the 3 results appear in order on consecutive cycles.
- XLEN=64: SRA of 0x8000000000000000 by 63 → all-ones. `op2[6]` set is ignored.
